// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives instruction-memory address, resolves J/JAL
// targets locally and registers each fetched word into the IF/ID register.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        if_id_valid,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        fetch_fault,
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_BYTES);
    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [5:0]  OP_JAL   = 6'b000011;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] jump_pc;
    logic [5:0]  opcode;
    logic        is_jump;
    logic        out_of_range;
    logic        redirect_misaligned;

    assign imem_addr           = pc;
    assign pc4                 = pc + 32'd4;
    assign opcode              = imem_inst[31:26];
    assign is_jump             = (opcode == OP_J) || (opcode == OP_JAL);
    // Region bits come from the sequential successor, not the J itself.
    assign jump_pc             = {pc4[31:28], imem_inst[25:0], 2'b00};
    assign out_of_range        = (pc >= PC_LIMIT);
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_inst  <= 32'd0;
            if_id_pc4   <= 32'd0;
            fetch_fault <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (redirect_valid && redirect_misaligned) begin
                        state       <= HALT;
                        halted      <= 1'b1;
                        fetch_fault <= 1'b1;
                        if_id_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        // Wins over stall: IF/ID holds a wrong-path word.
                        pc          <= redirect_pc;
                        if_id_valid <= 1'b0;
                    end else if (stall) begin
                        pc          <= pc;
                    end else if (halt_req) begin
                        state       <= HALT;
                        halted      <= 1'b1;
                        if_id_valid <= 1'b0;
                    end else if (out_of_range) begin
                        state       <= HALT;
                        halted      <= 1'b1;
                        fetch_fault <= 1'b1;
                        if_id_valid <= 1'b0;
                    end else begin
                        if_id_valid <= 1'b1;
                        if_id_inst  <= imem_inst;
                        if_id_pc4   <= pc4;
                        pc          <= is_jump ? jump_pc : pc4;
                    end
                end
                HALT: begin
                    if_id_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: begin
                    state       <= HALT;
                    halted      <= 1'b1;
                    if_id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (256-byte and 16-byte space) share the
// stimulus; a transaction-level model is compared every cycle, plus literals.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt_req = 1'b0;

    logic [31:0] addr_a, inst_a, iinst_a, pc4_a;
    logic        vld_a, fault_a, halted_a;
    logic [31:0] addr_b, inst_b, iinst_b, pc4_b;
    logic        vld_b, fault_b, halted_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Program image: J at 20, JAL at 132, filler words tagged with their address.
    function automatic logic [31:0] memword(input logic [31:0] addr);
        if (addr == 32'd20)       return 32'h0800_0020;
        else if (addr == 32'd132) return 32'h0C00_0003;
        else if (addr < 32'd256)  return 32'h1000_0000 | addr;
        else                      return 32'hDEAD_0000 | {16'd0, addr[15:0]};
    endfunction

    assign inst_a = memword(addr_a);
    assign inst_b = memword(addr_b);

    instr_fetch #(.RESET_PC(32'h0), .IMEM_BYTES(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr_a), .imem_inst(inst_a),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .if_id_valid(vld_a), .if_id_inst(iinst_a),
        .if_id_pc4(pc4_a), .fetch_fault(fault_a), .halted(halted_a)
    );

    instr_fetch #(.RESET_PC(32'h0), .IMEM_BYTES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr_b), .imem_inst(inst_b),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .if_id_valid(vld_b), .if_id_inst(iinst_b),
        .if_id_pc4(pc4_b), .fetch_fault(fault_b), .halted(halted_b)
    );

    // Model: mode 0 = just out of reset, 1 = fetching, 2 = stopped for good.
    typedef struct {
        int          mode;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        v;
        logic        fault;
        logic        halted;
    } ms_t;

    function automatic ms_t mreset();
        ms_t r;
        r.mode = 0; r.pc = 32'd0; r.inst = 32'd0; r.pc4 = 32'd0;
        r.v = 1'b0; r.fault = 1'b0; r.halted = 1'b0;
        return r;
    endfunction

    function automatic ms_t mstep(input ms_t s, input logic stl, input logic rv,
                                  input logic [31:0] rpc, input logic hr,
                                  input logic [31:0] lim);
        ms_t n = s;
        logic [31:0] w;
        logic [31:0] nxt;
        w   = memword(s.pc);
        nxt = s.pc + 32'd4;
        if (s.mode == 0) begin
            n.mode = 1;
        end else if (s.mode == 1) begin
            if (rv && (rpc % 4 != 0)) begin
                n.mode = 2; n.halted = 1'b1; n.fault = 1'b1; n.v = 1'b0;
            end else if (rv) begin
                n.pc = rpc; n.v = 1'b0;
            end else if (stl) begin
                n = s;
            end else if (hr) begin
                n.mode = 2; n.halted = 1'b1; n.v = 1'b0;
            end else if (s.pc >= lim) begin
                n.mode = 2; n.halted = 1'b1; n.fault = 1'b1; n.v = 1'b0;
            end else begin
                n.v = 1'b1; n.inst = w; n.pc4 = nxt;
                if ((w >> 26) == 2 || (w >> 26) == 3)
                    n.pc = (nxt & 32'hF000_0000) + ((w & 32'h03FF_FFFF) * 4);
                else
                    n.pc = nxt;
            end
        end
        return n;
    endfunction

    ms_t ma = mreset();
    ms_t mb = mreset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, stall, redirect_valid, redirect_pc, halt_req, 32'd256);
            mb <= mstep(mb, stall, redirect_valid, redirect_pc, halt_req, 32'd16);
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check32("m.a.imem_addr", addr_a, ma.pc);
        check1 ("m.a.if_id_valid", vld_a, ma.v);
        check32("m.a.if_id_inst", iinst_a, ma.inst);
        check32("m.a.if_id_pc4", pc4_a, ma.pc4);
        check1 ("m.a.fetch_fault", fault_a, ma.fault);
        check1 ("m.a.halted", halted_a, ma.halted);
        check32("m.b.imem_addr", addr_b, mb.pc);
        check1 ("m.b.if_id_valid", vld_b, mb.v);
        check32("m.b.if_id_inst", iinst_b, mb.inst);
        check32("m.b.if_id_pc4", pc4_b, mb.pc4);
        check1 ("m.b.fetch_fault", fault_b, mb.fault);
        check1 ("m.b.halted", halted_b, mb.halted);
    end

    initial begin
        repeat (2) @(negedge clk);
        check32("rst.addr", addr_a, 32'd0);
        check1 ("rst.valid", vld_a, 1'b0);
        check32("rst.inst", iinst_a, 32'd0);
        check32("rst.pc4", pc4_a, 32'd0);
        check1 ("rst.halted", halted_a, 1'b0);
        check1 ("rst.fault", fault_a, 1'b0);
        rst_n = 1'b1;

        @(negedge clk);                       // BOOT edge
        check32("boot.addr", addr_a, 32'd0);
        check1 ("boot.valid", vld_a, 1'b0);
        @(negedge clk);                       // first fetch
        check1 ("f0.valid", vld_a, 1'b1);
        check32("f0.inst", iinst_a, 32'h1000_0000);
        check32("f0.pc4", pc4_a, 32'd4);
        check32("f0.addr", addr_a, 32'd4);
        @(negedge clk);
        check32("f1.addr", addr_a, 32'd8);

        stall = 1'b1;
        repeat (3) @(negedge clk);
        check32("stall.addr", addr_a, 32'd8);
        check32("stall.inst", iinst_a, 32'h1000_0004);
        check32("stall.pc4", pc4_a, 32'd8);
        check1 ("stall.valid", vld_a, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'd64;
        @(negedge clk);
        check32("redir.addr", addr_a, 32'd64);
        check1 ("redir.valid", vld_a, 1'b0);
        stall = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        check32("tgt.inst", iinst_a, 32'h1000_0040);
        check32("tgt.pc4", pc4_a, 32'd68);
        check1 ("tgt.valid", vld_a, 1'b1);

        redirect_valid = 1'b1; redirect_pc = 32'd16;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);                       // fetch 16
        @(negedge clk);                       // fetch the J at 20
        check32("j.inst", iinst_a, 32'h0800_0020);
        check32("j.pc4", pc4_a, 32'd24);
        check32("j.addr", addr_a, 32'd128);
        @(negedge clk);
        check1 ("jt.valid", vld_a, 1'b1);
        check32("jt.pc4", pc4_a, 32'd132);
        check32("jt.inst", iinst_a, 32'h1000_0080);
        @(negedge clk);                       // JAL at 132 -> 12
        check32("jal.inst", iinst_a, 32'h0C00_0003);
        check32("jal.pc4", pc4_a, 32'd136);
        check32("jal.addr", addr_a, 32'd12);

        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check1 ("hr.halted", halted_a, 1'b1);
        check1 ("hr.fault", fault_a, 1'b0);
        check1 ("hr.valid", vld_a, 1'b0);
        check32("hr.addr", addr_a, 32'd12);
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd64;
        repeat (2) @(negedge clk);
        check32("hr.frozen", addr_a, 32'd12);
        check1 ("hr.sticky", halted_a, 1'b1);
        stall = 1'b0; redirect_valid = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check32("arst.addr", addr_a, 32'd0);
        check1 ("arst.halted", halted_a, 1'b0);
        check1 ("arst.valid", vld_a, 1'b0);
        check32("arst.pc4", pc4_a, 32'd0);
        check1 ("arst.b.fault", fault_b, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);                       // BOOT
        check1 ("reboot.valid", vld_a, 1'b0);
        @(negedge clk);
        check32("reboot.inst", iinst_a, 32'h1000_0000);
        check32("reboot.pc4", pc4_a, 32'd4);
        repeat (3) @(negedge clk);            // fetched 4, 8, 12
        check1 ("oor.b.valid", vld_b, 1'b1);
        check32("oor.b.pc4", pc4_b, 32'd16);
        check32("oor.b.addr", addr_b, 32'd16);
        check1 ("oor.b.halted0", halted_b, 1'b0);
        @(negedge clk);
        check1 ("oor.b.halted", halted_b, 1'b1);
        check1 ("oor.b.fault", fault_b, 1'b1);
        check1 ("oor.b.valid0", vld_b, 1'b0);
        check32("oor.b.inst", iinst_b, 32'h1000_000C);
        check32("oor.a.addr", addr_a, 32'd20);

        redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
        @(negedge clk);
        check1 ("mis.halted", halted_a, 1'b1);
        check1 ("mis.fault", fault_a, 1'b1);
        check1 ("mis.valid", vld_a, 1'b0);
        check32("mis.addr", addr_a, 32'd20);
        redirect_pc = 32'd64;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b0;
        check32("mis.frozen", addr_a, 32'd20);
        check1 ("mis.valid1", vld_a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
